// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
//
// Interrupt entry/exit sequencer for the 5-stage MIPS pipeline (PM, DC, EX, DM, WB).
// The block latches rising edges on the request lines and stalls fetch while the
// pipeline drains. It then redirects the PC into a vector table and saves the
// return address (EPC). When the service routine signals return, it restores EPC.
// The redirect uses the same jmp_loc / pc_mux_sel path as jump control; the
// surrounding mux gives this block priority over jump control.
//
// Ports
//   clk              in   1        system clock, rising edge
//   reset            in   1        synchronous, active-high
//   irq              in   NUM_IRQ  raw request lines, rising-edge sensitive
//   mask_we          in   1        mask register write enable
//   mask_in          in   NUM_IRQ  new mask value (1 = enabled)
//   current_address  in   ADDR_W   PC of the instruction in fetch
//   branch_in_flight in   1        unresolved jump/branch; defers entry
//   iret             in   1        service-routine return pulse
//   stall_req        out  1        freeze fetch/decode (DRAIN state)
//   pc_mux_sel       out  1        select jmp_loc as next PC
//   jmp_loc          out  ADDR_W   redirect target (0 when pc_mux_sel=0)
//   irq_ack          out  NUM_IRQ  one-hot acknowledge pulse (VECTOR state)
//   epc              out  ADDR_W   saved return address
//   in_service       out  1        set leaving VECTOR, cleared leaving RETURN
//
// Configuration macro
//   IRQ_RR_EN : when defined, priority is round-robin. The search starts one past
//               the last served id. When undefined, priority is fixed and the
//               lowest index wins.
// -----------------------------------------------------------------------------
module irq_sequencer #(
  parameter int                NUM_IRQ      = 4,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE     = 'h0040,
  parameter int                VEC_STRIDE   = 4,
  parameter int                DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic [ADDR_W-1:0]  current_address,
  input  logic               branch_in_flight,
  input  logic               iret,
  output logic               stall_req,
  output logic               pc_mux_sel,
  output logic [ADDR_W-1:0]  jmp_loc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [ADDR_W-1:0]  epc,
  output logic               in_service
);

  localparam int ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_VECTOR,
    S_SERVICE,
    S_RETURN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               ie_q;
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  epc_q;
  logic               in_service_q;

  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    sel_id;
  logic               take;
  logic [ADDR_W-1:0]  vec_addr;

  // Lowest set index wins.
  function automatic logic [ID_W-1:0] pick_fixed(input logic [NUM_IRQ-1:0] req);
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) pick = ID_W'(i);
    end
    return pick;
  endfunction

`ifdef IRQ_RR_EN
  logic [ID_W-1:0] last_q;

  // The search starts one past the last served id and wraps around.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_IRQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_IRQ; k++) begin
      idx = (int'(last) + k) % NUM_IRQ;
      if (!found && req[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign sel_id = pick_rr(eligible, last_q);
`else
  assign sel_id = pick_fixed(eligible);
`endif

  assign edges    = irq & ~irq_q;
  assign eligible = pending_q & mask_q;
  assign vec_addr = VEC_BASE + (ADDR_W'(id_q) * ADDR_W'(VEC_STRIDE));
  assign epc        = epc_q;
  assign in_service = in_service_q;

  // Next-state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    take       = 1'b0;
    stall_req  = 1'b0;
    pc_mux_sel = 1'b0;
    jmp_loc    = '0;
    irq_ack    = '0;
    case (state_q)
      S_IDLE: begin
        // Entry waits for the branch to resolve, so EPC is never a wrong-path PC.
        if (ie_q && (eligible != '0) && !branch_in_flight) begin
          take    = 1'b1;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        if (cnt_q == '0) state_d = S_VECTOR;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_VECTOR: begin
        pc_mux_sel = 1'b1;
        jmp_loc    = vec_addr;
        irq_ack    = NUM_IRQ'(1) << id_q;
        state_d    = S_SERVICE;
      end
      S_SERVICE: begin
        if (iret) state_d = S_RETURN;
      end
      S_RETURN: begin
        pc_mux_sel = 1'b1;
        jmp_loc    = epc_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      ie_q         <= 1'b1;
      id_q         <= '0;
      epc_q        <= '0;
      in_service_q <= 1'b0;
`ifdef IRQ_RR_EN
      last_q       <= ID_W'(NUM_IRQ - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq;
      // A new edge on the bit being acknowledged stays pending (set wins).
      pending_q <= (pending_q & ~irq_ack) | edges;
      if (mask_we) mask_q <= mask_in;
      if (take) begin
        id_q  <= sel_id;
        epc_q <= current_address;
      end
      if (state_q == S_VECTOR) begin
        ie_q         <= 1'b0;
        in_service_q <= 1'b1;
`ifdef IRQ_RR_EN
        last_q       <= id_q;
`endif
      end
      if (state_q == S_RETURN) begin
        ie_q         <= 1'b1;
        in_service_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
module tb_irq_sequencer;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DR = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq = '0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_in = '0;
  logic [AW-1:0] current_address = '0;
  logic          branch_in_flight = 1'b0;
  logic          iret = 1'b0;
  logic          stall_req;
  logic          pc_mux_sel;
  logic [AW-1:0] jmp_loc;
  logic [N-1:0]  irq_ack;
  logic [AW-1:0] epc;
  logic          in_service;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  irq_sequencer #(
    .NUM_IRQ(N), .ADDR_W(AW), .VEC_BASE(16'h0040), .VEC_STRIDE(4), .DRAIN_CYCLES(DR)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .current_address(current_address), .branch_in_flight(branch_in_flight),
    .iret(iret), .stall_req(stall_req), .pc_mux_sel(pc_mux_sel),
    .jmp_loc(jmp_loc), .irq_ack(irq_ack), .epc(epc), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model. It tracks the activity phase: how many stall cycles are
  // left, and whether this is the vector, service or return cycle.
  int          m_stall;
  bit          m_vec, m_svc, m_ret, m_insvc;
  bit [N-1:0]  m_pend, m_mask, m_prev;
  int          m_id;
  bit [AW-1:0] m_epc;

  always @(posedge clk) begin : model
    bit [N-1:0] elig;
    bit [N-1:0] edg;
    bit         idle;
    if (reset) begin
      m_stall = 0; m_vec = 0; m_svc = 0; m_ret = 0; m_insvc = 0;
      m_pend = '0; m_mask = '1; m_prev = '0; m_id = 0; m_epc = '0;
    end else begin
      elig = m_pend & m_mask;
      edg  = irq & ~m_prev;
      idle = !(m_stall > 0 || m_vec || m_svc || m_ret);
      if (m_vec) m_pend[m_id] = 1'b0;
      m_pend = m_pend | edg;
      if (idle) begin
        if (elig != '0 && !branch_in_flight) begin
          m_id = 0;
          while (!elig[m_id]) m_id++;
          m_epc   = current_address;
          m_stall = DR;
        end
      end else if (m_stall > 0) begin
        m_stall--;
        if (m_stall == 0) m_vec = 1;
      end else if (m_vec) begin
        m_vec = 0; m_svc = 1; m_insvc = 1;
      end else if (m_svc) begin
        if (iret) begin m_svc = 0; m_ret = 1; end
      end else if (m_ret) begin
        m_ret = 0; m_insvc = 0;
      end
      if (mask_we) m_mask = mask_in;
      m_prev = irq;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : compare
    bit [AW-1:0] e_jmp;
    bit [N-1:0]  e_ack;
    if (chk_en) begin
      e_jmp = m_vec ? AW'(16'h0040 + m_id * 4) : (m_ret ? m_epc : '0);
      e_ack = m_vec ? N'(1 << m_id) : '0;
      chk("cyc stall_req",  32'(stall_req),  32'(m_stall > 0));
      chk("cyc pc_mux_sel", 32'(pc_mux_sel), 32'(m_vec || m_ret));
      chk("cyc jmp_loc",    32'(jmp_loc),    32'(e_jmp));
      chk("cyc irq_ack",    32'(irq_ack),    32'(e_ack));
      chk("cyc epc",        32'(epc),        32'(m_epc));
      chk("cyc in_service", 32'(in_service), 32'(m_insvc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vec(input string nm, input logic [AW-1:0] ej, input logic [N-1:0] ea);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (pc_mux_sel && irq_ack != '0) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s vector timeout: got no vector, expected jmp_loc %h", nm, ej);
    end else begin
      chk({nm, " jmp_loc"}, 32'(jmp_loc), 32'(ej));
      chk({nm, " irq_ack"}, 32'(irq_ack), 32'(ea));
    end
  endtask

  // Called in the VECTOR cycle; ends in IDLE after RETURN.
  task automatic do_return(input string nm, input logic [AW-1:0] eepc);
    step();
    chk({nm, " svc in_service"}, 32'(in_service), 32'd1);
    iret = 1'b1;
    step();
    iret = 1'b0;
    chk({nm, " ret pc_mux_sel"}, 32'(pc_mux_sel), 32'd1);
    chk({nm, " ret jmp_loc"},    32'(jmp_loc),    32'(eepc));
    step();
    chk({nm, " idle in_service"}, 32'(in_service), 32'd0);
  endtask

  initial begin
    repeat (2) step();
    chk_en = 1'b1;
    chk("reset stall_req",  32'(stall_req),  32'd0);
    chk("reset pc_mux_sel", 32'(pc_mux_sel), 32'd0);
    chk("reset jmp_loc",    32'(jmp_loc),    32'd0);
    chk("reset irq_ack",    32'(irq_ack),    32'd0);
    chk("reset epc",        32'(epc),        32'd0);
    reset = 1'b0;

    // 1) single request, three stall cycles, vector 0x0048
    current_address = 16'h0010;
    irq = 4'b0100;
    step();
    chk("t1 pre stall", 32'(stall_req), 32'd0);
    step(); chk("t1 stall1", 32'(stall_req), 32'd1);
    chk("t1 epc", 32'(epc), 32'h0010);
    step(); chk("t1 stall2", 32'(stall_req), 32'd1);
    step(); chk("t1 stall3", 32'(stall_req), 32'd1);
    step();
    chk("t1 vec stall",   32'(stall_req),  32'd0);
    chk("t1 vec pcsel",   32'(pc_mux_sel), 32'd1);
    chk("t1 vec jmp_loc", 32'(jmp_loc),    32'h0048);
    chk("t1 vec irq_ack", 32'(irq_ack),    32'b0100);
    do_return("t1", 16'h0010);

    // 2) simultaneous irq[1], irq[3]: 0x0044 then immediate re-entry to 0x004C
    irq = '0; step();
    current_address = 16'h0020;
    irq = 4'b1010;
    wait_vec("t2a", 16'h0044, 4'b0010);
    do_return("t2a", 16'h0020);
    step();
    chk("t2 reentry stall", 32'(stall_req), 32'd1);
    wait_vec("t2b", 16'h004C, 4'b1000);
    do_return("t2b", 16'h0020);

    // 3) masked request held pending until unmasked
    irq = '0;
    current_address = 16'h0030;
    mask_we = 1'b1; mask_in = 4'b1110;
    step();
    mask_we = 1'b0;
    irq = 4'b0001;
    repeat (8) step();
    chk("t3 masked stall", 32'(stall_req),  32'd0);
    chk("t3 masked pcsel", 32'(pc_mux_sel), 32'd0);
    mask_we = 1'b1; mask_in = 4'b1111;
    step();
    mask_we = 1'b0;
    wait_vec("t3", 16'h0040, 4'b0001);
    do_return("t3", 16'h0030);

    // 4) branch in flight defers entry
    irq = '0; step();
    current_address = 16'h0050;
    branch_in_flight = 1'b1;
    irq = 4'b0001;
    repeat (5) step();
    chk("t4 deferred stall", 32'(stall_req), 32'd0);
    branch_in_flight = 1'b0;
    step();
    chk("t4 entry stall", 32'(stall_req), 32'd1);
    wait_vec("t4", 16'h0040, 4'b0001);
    do_return("t4", 16'h0050);

    // 5) edge during SERVICE waits for iret, then re-enters; iret in IDLE ignored
    irq = '0; step();
    current_address = 16'h0060;
    irq = 4'b0001;
    wait_vec("t5a", 16'h0040, 4'b0001);
    step();
    irq = 4'b0011;
    repeat (5) step();
    chk("t5 svc pcsel", 32'(pc_mux_sel), 32'd0);
    chk("t5 svc stall", 32'(stall_req),  32'd0);
    iret = 1'b1; step(); iret = 1'b0;
    chk("t5 ret jmp_loc", 32'(jmp_loc), 32'h0060);
    step();
    wait_vec("t5b", 16'h0044, 4'b0010);
    do_return("t5b", 16'h0060);
    iret = 1'b1; step(); iret = 1'b0;
    repeat (3) step();
    chk("t5 idle iret pcsel", 32'(pc_mux_sel), 32'd0);
    chk("t5 idle iret stall", 32'(stall_req),  32'd0);

    // 6) reset mid-DRAIN
    irq = '0; step();
    current_address = 16'h0070;
    irq = 4'b0100;
    step(); step();
    chk("t6 drain stall", 32'(stall_req), 32'd1);
    chk("t6 drain epc",   32'(epc),       32'h0070);
    reset = 1'b1; irq = '0;
    step();
    chk("t6 rst stall", 32'(stall_req),  32'd0);
    chk("t6 rst pcsel", 32'(pc_mux_sel), 32'd0);
    chk("t6 rst epc",   32'(epc),        32'd0);
    reset = 1'b0;
    repeat (6) step();
    chk("t6 no pending stall", 32'(stall_req), 32'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
